// File: rtl/core_defs.sv
// Shared core definitions: register-index width, NOP encoding and the EX operand-mux select codes.
package core_defs;

   localparam int          REG_W = 5;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef enum logic [1:0] {
      FWD_REGFILE = 2'b00,
      FWD_WB      = 2'b01,
      FWD_MEM     = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/fwd_sel_gen.sv
// Next forwarding select for one ALU operand; purely combinational, no backpressure.
// The youngest producer (EX) wins over the older one (MEM); x0 and bubble slots always read the regfile.
module fwd_sel_gen #(
   parameter int REG_W = 5
) (
   input  logic             ex_v_i,
   input  logic             ex_wr_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic             mem_v_i,
   input  logic             mem_wr_i,
   input  logic [REG_W-1:0] mem_rd_i,
   input  logic [REG_W-1:0] rs_i,
   input  logic             use_rs_i,
   input  logic             slot_vld_i,
   output logic [1:0]       sel_o
);
   import core_defs::*;

   logic ex_hit;
   logic mem_hit;

   assign ex_hit  = ex_v_i  & ex_wr_i  & (|ex_rd_i)  & (ex_rd_i  == rs_i) & use_rs_i;
   assign mem_hit = mem_v_i & mem_wr_i & (|mem_rd_i) & (mem_rd_i == rs_i) & use_rs_i;

   always_comb begin
      sel_o = FWD_REGFILE;
      if (slot_vld_i) begin
         if (ex_hit) begin
            sel_o = FWD_MEM;
         end else if (mem_hit) begin
            sel_o = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX operand forwarding, load-use stall and taken-branch flush control; stall/flush same cycle, selects registered.
// No backpressure of its own: it generates the hold/bubble/flush that stall and squash the front end.
module fwd_hazard_ctrl #(
   parameter int REG_W = core_defs::REG_W,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             ex_branch_taken,
   output logic             pc_hold,
   output logic             if_id_hold,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);
   import core_defs::*;

   logic             ex_v_q,  ex_v_d;
   logic             ex_wr_q, ex_wr_d;
   logic             ex_ld_q, ex_ld_d;
   logic [REG_W-1:0] ex_rd_q, ex_rd_d;
   logic             mem_v_q,  mem_v_d;
   logic             mem_wr_q, mem_wr_d;
   logic [REG_W-1:0] mem_rd_q, mem_rd_d;
   logic [1:0]       fwd_a_q, fwd_a_d;
   logic [1:0]       fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic lu;
   logic fl;
   logic slot_vld;

   function automatic logic srcmatch(input logic v, input logic wr, input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs, input logic use_rs);
      return v & wr & (|rd) & (rd == rs) & use_rs;
   endfunction

   assign lu = id_valid & ex_ld_q &
               (srcmatch(ex_v_q, ex_wr_q, ex_rd_q, id_rs1, id_use_rs1) |
                srcmatch(ex_v_q, ex_wr_q, ex_rd_q, id_rs2, id_use_rs2));
   assign fl = ex_branch_taken;

   // Only a real instruction that is neither stalled nor squashed occupies EX next cycle.
   assign slot_vld = id_valid & ~lu & ~fl;

   assign pc_hold      = ~rst & lu & ~fl;
   assign if_id_hold   = ~rst & lu & ~fl;
   assign id_ex_bubble = ~rst & (lu | fl);
   assign if_id_flush  = ~rst & fl;

   fwd_sel_gen #(.REG_W(REG_W)) u_sel_a (
      .ex_v_i    (ex_v_q),
      .ex_wr_i   (ex_wr_q),
      .ex_rd_i   (ex_rd_q),
      .mem_v_i   (mem_v_q),
      .mem_wr_i  (mem_wr_q),
      .mem_rd_i  (mem_rd_q),
      .rs_i      (id_rs1),
      .use_rs_i  (id_use_rs1),
      .slot_vld_i(slot_vld),
      .sel_o     (fwd_a_d)
   );

   fwd_sel_gen #(.REG_W(REG_W)) u_sel_b (
      .ex_v_i    (ex_v_q),
      .ex_wr_i   (ex_wr_q),
      .ex_rd_i   (ex_rd_q),
      .mem_v_i   (mem_v_q),
      .mem_wr_i  (mem_wr_q),
      .mem_rd_i  (mem_rd_q),
      .rs_i      (id_rs2),
      .use_rs_i  (id_use_rs2),
      .slot_vld_i(slot_vld),
      .sel_o     (fwd_b_d)
   );

   always_comb begin
      ex_v_d      = slot_vld;
      ex_rd_d     = id_rd;
      ex_wr_d     = id_reg_write;
      ex_ld_d     = id_mem_read;
      mem_v_d     = ex_v_q;
      mem_rd_d    = ex_rd_q;
      mem_wr_d    = ex_wr_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (lu & ~fl) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (fl) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_v_q      <= 1'b0;
         ex_wr_q     <= 1'b0;
         ex_ld_q     <= 1'b0;
         ex_rd_q     <= '0;
         mem_v_q     <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_rd_q    <= '0;
         fwd_a_q     <= FWD_REGFILE;
         fwd_b_q     <= FWD_REGFILE;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_v_q      <= ex_v_d;
         ex_wr_q     <= ex_wr_d;
         ex_ld_q     <= ex_ld_d;
         ex_rd_q     <= ex_rd_d;
         mem_v_q     <= mem_v_d;
         mem_wr_q    <= mem_wr_d;
         mem_rd_q    <= mem_rd_d;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fwd_a_sel   = fwd_a_q;
   assign fwd_b_sel   = fwd_b_q;
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed program sequences with literal expectations, then random instruction streams.
module tb_fwd_hazard_ctrl;
   localparam int RW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid;
   logic [RW-1:0] id_rs1, id_rs2, id_rd;
   logic          id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
   logic          ex_branch_taken;
   logic          pc_hold, if_id_hold, id_ex_bubble, if_id_flush;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic [CW-1:0] stall_count, flush_count;

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
      .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_bubble(id_ex_bubble),
      .if_id_flush(if_id_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   // One record per EX entry; the last two entries are the instructions now in EX and MEM.
   typedef struct {
      bit v;
      int rd;
      bit wr;
      bit ld;
   } ent_t;

   ent_t hist[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   m_a, m_b, m_stall, m_flush;
   bit   last_hold;

   function automatic bit writes(ent_t e, int rs, bit use_rs);
      return e.v && e.wr && e.rd != 0 && e.rd == rs && use_rs;
   endfunction

   // Search from the youngest older instruction backwards; distance 1 -> MEM result, 2 -> WB data.
   function automatic int pick(int rs, bit use_rs);
      for (int age = 1; age <= 2; age++) begin
         if (writes(hist[hist.size() - age], rs, use_rs)) return (age == 1) ? 2 : 1;
      end
      return 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_hist();
      ent_t inv;
      inv = '{v: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
      hist.delete();
      hist.push_back(inv);
      hist.push_back(inv);
   endtask

   task automatic cyc();
      ent_t ex;
      ent_t nw;
      bit   lu, fl, slot;
      @(negedge clk);
      #1;
      ex = hist[hist.size() - 1];
      lu = id_valid && ex.ld && (writes(ex, id_rs1, id_use_rs1) || writes(ex, id_rs2, id_use_rs2));
      fl = ex_branch_taken;
      check("pc_hold",      32'(pc_hold),      32'(!rst && lu && !fl));
      check("if_id_hold",   32'(if_id_hold),   32'(!rst && lu && !fl));
      check("id_ex_bubble", 32'(id_ex_bubble), 32'(!rst && (lu || fl)));
      check("if_id_flush",  32'(if_id_flush),  32'(!rst && fl));
      check("fwd_a_sel",    32'(fwd_a_sel),    m_a);
      check("fwd_b_sel",    32'(fwd_b_sel),    m_b);
      check("stall_count",  32'(stall_count),  m_stall);
      check("flush_count",  32'(flush_count),  m_flush);
      last_hold = !rst && lu && !fl;
      if (rst) begin
         clear_hist();
         m_a = 0; m_b = 0; m_stall = 0; m_flush = 0;
      end else begin
         slot = id_valid && !lu && !fl;
         m_a  = slot ? pick(id_rs1, id_use_rs1) : 0;
         m_b  = slot ? pick(id_rs2, id_use_rs2) : 0;
         nw   = '{v: slot, rd: int'(id_rd), wr: id_reg_write, ld: id_mem_read};
         hist.push_back(nw);
         void'(hist.pop_front());
         if (lu && !fl) m_stall = (m_stall + 1) % (1 << CW);
         if (fl)        m_flush = (m_flush + 1) % (1 << CW);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit wr, input bit ld);
      id_valid = 1'b1;
      id_rs1 = RW'(rs1); id_rs2 = RW'(rs2);
      id_use_rs1 = u1; id_use_rs2 = u2;
      id_rd = RW'(rd); id_reg_write = wr; id_mem_read = ld;
   endtask

   task automatic bubble();
      instr(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      id_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ex_branch_taken = 1'b0; last_hold = 1'b0;
      bubble();
      clear_hist();
      m_a = 0; m_b = 0; m_stall = 0; m_flush = 0;
      @(posedge clk); #1;
      cyc();
      rst = 1'b0;
      check("reset_sel_a", 32'(fwd_a_sel), 0);
      check("reset_stall", 32'(stall_count), 0);

      // add x5,x1,x2 ; add x6,x5,x3
      instr(1, 2, 1, 1, 5, 1, 0); cyc();
      instr(5, 3, 1, 1, 6, 1, 0); cyc();
      check("t1_sel_a", 32'(fwd_a_sel), 2);
      check("t1_sel_b", 32'(fwd_b_sel), 0);

      // add x5 ; nop ; sub x7,x1,x5
      instr(1, 2, 1, 1, 5, 1, 0); cyc();
      bubble(); cyc();
      instr(1, 5, 1, 1, 7, 1, 0); cyc();
      check("t2_sel_a", 32'(fwd_a_sel), 0);
      check("t2_sel_b", 32'(fwd_b_sel), 1);

      // add x5 ; add x5 ; or x8,x5,x5
      instr(1, 2, 1, 1, 5, 1, 0); cyc();
      instr(1, 2, 1, 1, 5, 1, 0); cyc();
      instr(5, 5, 1, 1, 8, 1, 0); cyc();
      check("t3_sel_a", 32'(fwd_a_sel), 2);
      check("t3_sel_b", 32'(fwd_b_sel), 2);

      // lw x5 ; add x6,x5,x5
      instr(1, 0, 1, 0, 5, 1, 1); cyc();
      instr(5, 5, 1, 1, 6, 1, 0); #1;
      check("t4_pc_hold", 32'(pc_hold), 1);
      check("t4_bubble",  32'(id_ex_bubble), 1);
      cyc(); #1;
      check("t4_hold_released", 32'(pc_hold), 0);
      cyc();
      check("t4_sel_a", 32'(fwd_a_sel), 1);
      check("t4_sel_b", 32'(fwd_b_sel), 1);
      check("t4_stall_count", 32'(stall_count), 1);

      // lw x0 ; add x6,x0,x0, then an invalid producer of x5
      instr(1, 0, 1, 0, 0, 1, 1); cyc();
      instr(0, 0, 1, 1, 6, 1, 0); #1;
      check("t5_x0_no_stall", 32'(pc_hold), 0);
      cyc();
      check("t5_x0_sel_a", 32'(fwd_a_sel), 0);
      instr(1, 2, 1, 1, 5, 1, 1); id_valid = 1'b0; cyc();
      instr(5, 5, 1, 1, 6, 1, 0); #1;
      check("t5_invalid_no_stall", 32'(pc_hold), 0);
      cyc();
      check("t5_invalid_sel_b", 32'(fwd_b_sel), 0);

      // branch taken while a load-use sits in ID
      instr(1, 0, 1, 0, 5, 1, 1); cyc();
      instr(5, 5, 1, 1, 6, 1, 0); ex_branch_taken = 1'b1; #1;
      check("t6_flush",   32'(if_id_flush), 1);
      check("t6_bubble",  32'(id_ex_bubble), 1);
      check("t6_pc_hold", 32'(pc_hold), 0);
      cyc();
      ex_branch_taken = 1'b0;
      check("t6_flush_count", 32'(flush_count), 1);
      check("t6_stall_count", 32'(stall_count), 1);

      // reset in the middle of a load-use stall
      bubble(); cyc();
      instr(1, 0, 1, 0, 5, 1, 1); cyc();
      instr(5, 5, 1, 1, 6, 1, 0); rst = 1'b1; #1;
      check("t6r_pc_hold", 32'(pc_hold), 0);
      check("t6r_bubble",  32'(id_ex_bubble), 0);
      cyc();
      rst = 1'b0; #1;
      check("t6r_stall_count", 32'(stall_count), 0);
      check("t6r_flush_count", 32'(flush_count), 0);
      check("t6r_no_stall_after", 32'(pc_hold), 0);
      cyc();

      // random instruction streams over a small register set to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         ex_branch_taken = ($urandom_range(0, 9) == 0);
         if (!last_hold) begin
            id_valid     = ($urandom_range(0, 9) != 0);
            id_rs1       = RW'($urandom_range(0, 3));
            id_rs2       = RW'($urandom_range(0, 3));
            id_use_rs1   = ($urandom_range(0, 3) != 0);
            id_use_rs2   = ($urandom_range(0, 3) != 0);
            id_rd        = RW'($urandom_range(0, 3));
            id_reg_write = ($urandom_range(0, 4) != 0);
            id_mem_read  = ($urandom_range(0, 2) == 0);
         end
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
